prienc_digit_entry: RTL and testbench

Parametrised successor to the combinational push-button priority encoder and hex seven-segment decoder pair. Synchronises and debounces an NIN-wide button bank and encodes the highest-priority pressed button. Each accepted press is shifted as a hex digit into a DIGITS-deep entry register. Drives DIGITS seven-segment digits with unused digits blanked. Sits between the pb[] inputs and the ss7..ss0 outputs in top.

---
 rtl/prienc_pkg.sv | 25 ++
 rtl/hex_seg.sv | 12 +
 rtl/prienc_digit_entry.sv | 161 ++++++++++++++++
 tb/tb_prienc_digit_entry.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/prienc_pkg.sv
// Shared types and constants for the push-button digit entry block:
// FSM states, the hex seven-segment table and a constant clog2 helper.
package prienc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HELD,
        REL
    } state_t;

    // Segment patterns in gfedcba order; index 15 is leftmost.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hex_seg.sv
// One seven-segment digit: 4-bit hex value to {dp, gfedcba}, forced dark when blanked.
module hex_seg
    import prienc_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    assign seg_o = blank_i ? 8'h00 : {1'b0, HEX_SEG[val_i]};

endmodule

// File: rtl/prienc_digit_entry.sv
// Debounced priority-encoded button bank feeding a shift-in hex digit entry
// register, with registered seven-segment drive for every digit position.
module prienc_digit_entry
    import prienc_pkg::*;
#(
    parameter int NIN      = 16,
    parameter int DIGITS   = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic                           hz100,
    input  logic                           reset,
    input  logic [NIN-1:0]                 in,
    input  logic                           clr,
    input  logic                           bksp,
    output logic [3:0]                     code,
    output logic                           strobe,
    output logic [4*DIGITS-1:0]            value,
    output logic [clog2(DIGITS+1)-1:0]     count,
    output logic [8*DIGITS-1:0]            seg
);

    localparam int CW = clog2(DIGITS + 1);
    localparam int DW = (DEBOUNCE > 1) ? clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] CNT_MAX    = DW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] DIGIT_FULL = CW'(DIGITS);

    logic [NIN-1:0]         meta_q, sync_q;
    logic [3:0]             enc;
    logic                   any;
    logic                   accept;

    state_t                 state_q;
    logic [3:0]             cand_q;
    logic [DW-1:0]          cnt_q;
    logic [3:0]             code_q;
    logic                   strobe_q;

    logic [4*DIGITS-1:0]    value_d, value_q;
    logic [CW-1:0]          count_d, count_q;
    logic [8*DIGITS-1:0]    seg_d, seg_q;
    logic [DIGITS-1:0]      blank;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= in;
            sync_q <= meta_q;
        end
    end

    // NOTE: enc gets a default before the loop, otherwise no-button cycles would infer a latch.
    always_comb begin
        enc = 4'h0;
        any = |sync_q;
        for (int i = 0; i < NIN; i++) begin
            if (sync_q[i]) enc = 4'(i);
        end
    end

    assign accept = (state_q == ARM) && any && (enc == cand_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cand_q   <= 4'h0;
            cnt_q    <= '0;
            code_q   <= 4'h0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q <= ARM;
                        cand_q  <= enc;
                        cnt_q   <= '0;
                    end
                end
                ARM: begin
                    if (!any) begin
                        state_q <= IDLE;
                    end else if (enc != cand_q) begin
                        cand_q <= enc;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q  <= HELD;
                        code_q   <= cand_q;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Extra or changed buttons while held never produce a new press.
                HELD: begin
                    if (!any) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                end
                REL: begin
                    if (any) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Clear beats a press, which beats backspace; a dropped press still strobes.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (accept) begin
            value_d      = value_q << 4;
            value_d[3:0] = cand_q;
            count_d      = (count_q == DIGIT_FULL) ? count_q : count_q + 1'b1;
        end else if (bksp && (count_q != '0)) begin
            value_d = value_q >> 4;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            count_q <= '0;
            seg_q   <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            seg_q   <= seg_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign blank[g] = (CW'(g) >= count_q);
        hex_seg u_hex_seg (
            .val_i   (value_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_d[8*g +: 8])
        );
    end

    assign code   = code_q;
    assign strobe = strobe_q;
    assign value  = value_q;
    assign count  = count_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_prienc_digit_entry.sv
// Directed bench for prienc_digit_entry (NIN=16, DIGITS=8, DEBOUNCE=4) with
// hand-computed expectations; inputs driven and outputs sampled at negedge.
module tb_prienc_digit_entry;

    logic        hz100;
    logic        reset;
    logic [15:0] in;
    logic        clr;
    logic        bksp;
    logic [3:0]  code;
    logic        strobe;
    logic [31:0] value;
    logic [3:0]  count;
    logic [63:0] seg;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int e_seen;
    int s0;

    prienc_digit_entry #(
        .NIN      (16),
        .DIGITS   (8),
        .DEBOUNCE (4)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .in     (in),
        .clr    (clr),
        .bksp   (bksp),
        .code   (code),
        .strobe (strobe),
        .value  (value),
        .count  (count),
        .seg    (seg)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    always @(posedge hz100) if (strobe === 1'b1) n_strobe <= n_strobe + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns the edge index (0 = first edge after call) whose cycle shows strobe, or -1.
    task automatic wait_strobe(output int e_out);
        e_out = -1;
        for (int e = 0; e < 40; e++) begin
            @(negedge hz100);
            if (strobe === 1'b1) begin
                e_out = e;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in = '0;
        repeat (n) @(negedge hz100);
    endtask

    task automatic press(input string tag, input logic [15:0] m, input logic [3:0] exp_code);
        int e;
        in = m;
        wait_strobe(e);
        check({tag, "_lat"}, 64'(e), 64'd6);
        check({tag, "_code"}, 64'(code), 64'(exp_code));
        idle(10);
    endtask

    initial begin
        reset = 1'b0;
        in    = '0;
        clr   = 1'b0;
        bksp  = 1'b0;

        // Reset state, then a quiet bank.
        @(negedge hz100);
        check("rst_code", 64'(code), 64'h0);
        check("rst_strobe", 64'(strobe), 64'h0);
        check("rst_value", 64'(value), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_seg", seg, 64'h0);
        reset = 1'b1;
        idle(21);
        check("quiet_strobes", 64'(n_strobe), 64'd0);
        check("quiet_value", 64'(value), 64'h0);
        check("quiet_count", 64'(count), 64'h0);
        check("quiet_seg", seg, 64'h0);

        // Single press of in[5]: strobe only after edge 6.
        in = 16'h0020;
        for (int e = 0; e < 10; e++) begin
            @(negedge hz100);
            check($sformatf("p5_strobe_e%0d", e), 64'(strobe), (e == 6) ? 64'h1 : 64'h0);
            if (e == 6) begin
                check("p5_code", 64'(code), 64'h5);
                check("p5_value", 64'(value), 64'h5);
                check("p5_count", 64'(count), 64'h1);
            end
            if (e == 7) check("p5_seg", 64'(seg[7:0]), 64'h6D);
        end
        idle(10);

        // Two buttons: the higher index wins; dropping one while held is ignored.
        in = 16'h1008;
        wait_strobe(e_seen);
        check("p12_lat", 64'(e_seen), 64'd6);
        check("p12_code", 64'(code), 64'hC);
        check("p12_value", 64'(value), 64'h5C);
        in = 16'h0008;
        @(negedge hz100);
        s0 = n_strobe;
        repeat (10) @(negedge hz100);
        check("p12_partial_release", 64'(n_strobe - s0), 64'd0);
        idle(10);
        press("p3", 16'h0008, 4'h3);
        check("p3_value", 64'(value), 64'h5C3);
        check("p3_count", 64'(count), 64'h3);

        // Bounce on in[7] before a stable hold.
        s0 = n_strobe;
        in = 16'h0080; @(negedge hz100);
        in = 16'h0000; @(negedge hz100);
        in = 16'h0080; @(negedge hz100);
        in = 16'h0000; @(negedge hz100);
        press("p7", 16'h0080, 4'h7);
        check("p7_strobes", 64'(n_strobe - s0), 64'd1);
        check("p7_value", 64'(value), 64'h5C37);
        check("p7_count", 64'(count), 64'h4);

        // Clear, then overfill with nine presses.
        clr = 1'b1;
        @(negedge hz100);
        clr = 1'b0;
        check("clr_value", 64'(value), 64'h0);
        check("clr_count", 64'(count), 64'h0);
        for (int d = 1; d <= 9; d++) press($sformatf("fill%0d", d), 16'(1 << d), 4'(d));
        check("full_value", 64'(value), 64'h23456789);
        check("full_count", 64'(count), 64'h8);
        check("full_seg", seg, 64'h5B4F666D7D077F67);

        bksp = 1'b1;
        @(negedge hz100);
        bksp = 1'b0;
        check("bksp_value", 64'(value), 64'h02345678);
        check("bksp_count", 64'(count), 64'h7);
        @(negedge hz100);
        check("bksp_seg", seg, 64'h005B4F666D7D077F);

        // Clear landing on the strobe edge drops the digit but keeps the pulse.
        in = 16'h0010;
        for (int e = 0; e < 7; e++) begin
            @(negedge hz100);
            if (e == 5) clr = 1'b1;
            if (e == 6) begin
                clr = 1'b0;
                check("clrp_strobe", 64'(strobe), 64'h1);
                check("clrp_code", 64'(code), 64'h4);
                check("clrp_value", 64'(value), 64'h0);
                check("clrp_count", 64'(count), 64'h0);
            end
        end
        idle(10);

        // Backspace on an empty register is a no-op.
        bksp = 1'b1;
        @(negedge hz100);
        bksp = 1'b0;
        check("bksp0_value", 64'(value), 64'h0);
        check("bksp0_count", 64'(count), 64'h0);

        press("p1", 16'h0002, 4'h1);
        check("p1_value", 64'(value), 64'h1);

        // Reset while armed with cnt=2, button kept down through release.
        in = 16'h0004;
        repeat (5) @(negedge hz100);
        reset = 1'b0;
        #1;
        check("mid_rst_code", 64'(code), 64'h0);
        check("mid_rst_value", 64'(value), 64'h0);
        check("mid_rst_count", 64'(count), 64'h0);
        check("mid_rst_seg", seg, 64'h0);
        check("mid_rst_strobe", 64'(strobe), 64'h0);
        @(negedge hz100);
        reset = 1'b1;
        wait_strobe(e_seen);
        check("post_rst_lat", 64'(e_seen), 64'd6);
        check("post_rst_code", 64'(code), 64'h2);
        check("post_rst_value", 64'(value), 64'h2);
        check("post_rst_count", 64'(count), 64'h1);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
